fmap_buffer: RTL and testbench
==============================

# fmap_buffer

Dual-port feature-map buffer that answers the CNN pipeline's BRAM-style read/write requests (read port for in-place consumers such as the activation pass, write port for write-back). It holds CHANNELS×IMG_SIZE×IMG_SIZE signed words in channel-major order (address = (ch·IMG_SIZE + row)·IMG_SIZE + col). It also provides a sequential clear engine and out-of-range detection. It sits between the convolution stage, the in-place activation stage and the pooling stage as the shared conv buffer.

## Interface
- DATA_WIDTH, 16, word width (signed two's complement)
- CHANNELS, 8, feature-map channels
- IMG_SIZE, 28, feature-map height = width
- DEPTH (localparam), CHANNELS·IMG_SIZE², number of stored words (6272 by default)
- AW (localparam), $clog2(DEPTH), address width (13 by default)

Clock/reset: reset reset, synchronous, active-high; clock clk.
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- r_en  in  1  read request
- r_addr  in  AW  read address
- r_q  out  DATA_WIDTH signed  read data, registered
- w_en  in  1  write port enable
- w_we  in  1  write strobe; a write occurs only when w_en && w_we
- w_addr  in  AW  write address
- w_d  in  DATA_WIDTH signed  write data
- clear  in  1  one-cycle pulse; starts zeroing all DEPTH words
- busy  out  1  clear engine active
- clear_done  out  1  one-cycle pulse when the clear completes
- oor_err  out  1  sticky; set by any access with address ≥ DEPTH

## Operation
- States: IDLE, CLEAR.
- IDLE + clear → CLEAR, clear counter = 0, oor_err ← 0.
- In CLEAR, word[counter] ← 0 each cycle and counter increments.
- After writing word DEPTH−1 → IDLE, clear_done = 1 for one cycle, busy = 0.
- A clear pulse while in CLEAR is ignored.
- During CLEAR: external writes are dropped. A read request updates r_q to 0, whatever the address.
- Read in IDLE: r_en with r_addr < DEPTH → r_q = word[r_addr] on the next cycle. With r_addr ≥ DEPTH → r_q = 0 and oor_err is set.
- Write in IDLE: w_en && w_we with w_addr < DEPTH → word[w_addr] ← w_d. With w_addr ≥ DEPTH → no write, oor_err is set.
- w_en without w_we is a no-op and never sets oor_err.
- Read/write collision (same address, same cycle, both valid) is write-first: r_q returns the new w_d.
- r_q holds its value while r_en = 0.
- Reset does not alter memory contents.

## Timing
- Reset values: r_q = 0, busy = 0, clear_done = 0, oor_err = 0, state IDLE, counter = 0.
- Read latency: 1 cycle. Request at edge N, data valid after edge N+1.
- Back-to-back reads at one per cycle are supported. A consumer issuing read N+1 in the same cycle as write-back to N sees no interaction.
- Write latency: a write at edge N is visible to a read issued at edge N (write-first) or later.
- busy rises on the edge after the clear pulse and stays high for exactly DEPTH cycles.
- clear_done pulses on the cycle busy falls.
- A read or write issued the same cycle as the clear pulse is served normally, as in IDLE.
- Reset during CLEAR aborts the clear immediately (busy = 0, no clear_done). Partially cleared contents are left as-is.
- oor_err is set the cycle after the offending access. It is cleared only by reset or by clear start.

## Structure
- Shared package cnn_pkg holds:
  - fmap_depth(CHANNELS, IMG_SIZE) function and its AW helper
  - lin3 (channel-major) address function, reused by the producer and consumer stages
  - fmap_word_t typedef (signed DATA_WIDTH)
- Sub-module fmap_ram_core: plain write-first single-clock dual-port memory array (one read port, one write port, registered output) so synthesis infers BRAM.
- The wrapper owns the clear FSM, write/read muxing, range checks and oor_err.

## Test plan
- Write 0x7FFF to addr 0, 0x8001 to addr 6271, then read both → r_q = 0x7FFF and 0x8001, each one cycle after its request. oor_err stays 0.
- In-place pattern: read addr k and write addr k−1 on the same edge for k = 1..100 over a pre-loaded ramp → every read returns the pre-loaded value.
- Collision: write 0x1234 to addr 50 with a read of addr 50 on the same edge → r_q = 0x1234 next cycle.
- Out of range: write to addr 6272, then read addr 8191 → no memory change, r_q = 0, oor_err = 1 and it stays 1. A following clear drops it to 0.
- Clear: pulse clear → busy high for exactly 6272 cycles, then clear_done pulses once. A write during the clear is dropped. All words read 0 afterwards.
- Reset at clear cycle 100 → busy = 0, no clear_done. Words 0..99 read 0, word 200 keeps its prior value.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN types and helpers: feature-map sizing, channel-major addressing, clear FSM states.
// Latency: none (types and constant functions only).
// Backpressure: none.
package cnn_pkg;

  localparam int FMAP_DATA_WIDTH = 16;

  typedef logic signed [FMAP_DATA_WIDTH-1:0] fmap_word_t;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clr_state_t;

  // Number of words held for a CHANNELS x IMG_SIZE x IMG_SIZE feature map.
  function automatic int fmap_depth(input int channels, input int img_size);
    return channels * img_size * img_size;
  endfunction

  // Address width that covers fmap_depth words.
  function automatic int fmap_aw(input int channels, input int img_size);
    return $clog2(fmap_depth(channels, img_size));
  endfunction

  // Channel-major linear address: (ch*IMG + row)*IMG + col.
  function automatic int lin3(input int ch, input int row, input int col, input int img_size);
    return (ch * img_size + row) * img_size + col;
  endfunction

endpackage

// File: rtl/fmap_ram_core.sv
// Plain single-clock dual-port memory array, one read port and one write port, write-first.
// Latency: 1 cycle read (registered q); writes visible to a same-edge read of the same address.
// Backpressure: none; q holds while re is low.
module fmap_ram_core #(
  parameter int DW    = 16,
  parameter int DEPTH = 6272,
  parameter int AW    = 13
) (
  input  logic                 clk,
  input  logic                 re,
  input  logic [AW-1:0]        raddr,
  output logic signed [DW-1:0] q,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic signed [DW-1:0] wd
);

  logic signed [DW-1:0] mem [DEPTH];

  // Array write and registered read; a same-address collision forwards the new data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wd;
    end
    if (re) begin
      q <= (we && (waddr == raddr)) ? wd : mem[raddr];
    end
  end

endmodule

// File: rtl/fmap_buffer.sv
// Shared conv feature-map buffer with a sequential clear engine and sticky out-of-range flag.
// Latency: 1 cycle read, write-first; clear takes DEPTH cycles with busy high.
// Backpressure: none; writes are dropped and reads return 0 while busy.
module fmap_buffer
  import cnn_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int CHANNELS   = 8,
  parameter  int IMG_SIZE   = 28,
  localparam int DEPTH      = fmap_depth(CHANNELS, IMG_SIZE),
  localparam int AW         = fmap_aw(CHANNELS, IMG_SIZE)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         r_en,
  input  logic [AW-1:0]                r_addr,
  output logic signed [DATA_WIDTH-1:0] r_q,
  input  logic                         w_en,
  input  logic                         w_we,
  input  logic [AW-1:0]                w_addr,
  input  logic signed [DATA_WIDTH-1:0] w_d,
  input  logic                         clear,
  output logic                         busy,
  output logic                         clear_done,
  output logic                         oor_err
);

  clr_state_t                   state;
  logic [AW-1:0]                clr_cnt;
  logic                         r_oor;
  logic                         w_oor;
  logic                         wr_req;
  logic                         mem_re;
  logic                         mem_we;
  logic [AW-1:0]                mem_waddr;
  logic signed [DATA_WIDTH-1:0] mem_wd;
  logic signed [DATA_WIDTH-1:0] core_q;
  logic                         rd_zero;

  assign r_oor  = (32'(r_addr) >= 32'(DEPTH));
  assign w_oor  = (32'(w_addr) >= 32'(DEPTH));
  assign wr_req = w_en && w_we;
  assign mem_re = r_en && !r_oor && (state == CLR_IDLE);

  // Write-port mux: the clear engine owns the port while clearing; reset blocks all writes
  // so an aborted clear leaves memory exactly as the last completed step left it.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = w_addr;
    mem_wd    = w_d;
    if (state == CLR_CLEAR) begin
      mem_we    = !reset;
      mem_waddr = clr_cnt;
      mem_wd    = '0;
    end else begin
      mem_we    = wr_req && !w_oor && !reset;
    end
  end

  fmap_ram_core #(
    .DW    (DATA_WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .re    (mem_re),
    .raddr (r_addr),
    .q     (core_q),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wd    (mem_wd)
  );

  // Remember whether the last accepted read must return 0 (clearing or out of range);
  // only updated on a read so r_q holds between requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_zero <= 1'b1;
    end else if (r_en) begin
      rd_zero <= (state == CLR_CLEAR) || r_oor;
    end
  end

  assign r_q = rd_zero ? '0 : core_q;

  // Clear FSM with registered busy/clear_done and the sticky out-of-range flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLR_IDLE;
      clr_cnt    <= '0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
      oor_err    <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        CLR_IDLE: begin
          if (clear) begin
            state   <= CLR_CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
          end
          oor_err <= (oor_err && !clear) || (r_en && r_oor) || (wr_req && w_oor);
        end
        CLR_CLEAR: begin
          if (clr_cnt == AW'(DEPTH - 1)) begin
            state      <= CLR_IDLE;
            clr_cnt    <= '0;
            busy       <= 1'b0;
            clear_done <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= CLR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fmap_buffer.sv
// Self-checking bench for fmap_buffer against an array-based reference model.
// Latency: model expects read data one edge after the request, write-first on collision.
// Backpressure: none exercised beyond the clear engine's busy window.
module tb_fmap_buffer;
  import cnn_pkg::*;

  localparam int DEPTH = fmap_depth(8, 28);
  localparam int AW    = fmap_aw(8, 28);

  logic              clk = 1'b0;
  logic              reset;
  logic              r_en;
  logic [AW-1:0]     r_addr;
  logic signed [15:0] r_q;
  logic              w_en;
  logic              w_we;
  logic [AW-1:0]     w_addr;
  logic signed [15:0] w_d;
  logic              clear;
  logic              busy;
  logic              clear_done;
  logic              oor_err;

  int n_checks = 0;
  int n_fail   = 0;

  fmap_word_t model [DEPTH];
  fmap_word_t exp_q;
  logic       exp_oor;

  always #5 clk = ~clk;

  fmap_buffer #(
    .DATA_WIDTH (16),
    .CHANNELS   (8),
    .IMG_SIZE   (28)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .r_en       (r_en),
    .r_addr     (r_addr),
    .r_q        (r_q),
    .w_en       (w_en),
    .w_we       (w_we),
    .w_addr     (w_addr),
    .w_d        (w_d),
    .clear      (clear),
    .busy       (busy),
    .clear_done (clear_done),
    .oor_err    (oor_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    r_en = 1'b0; r_addr = '0; w_en = 1'b0; w_we = 1'b0; w_addr = '0; w_d = '0; clear = 1'b0;
  endtask

  // One IDLE-mode cycle: drive, clock, apply the access rules to the model, compare.
  task automatic step(input bit re, input int ra, input bit we_en, input bit we,
                      input int wa, input logic [15:0] wd);
    r_en = re; r_addr = AW'(ra); w_en = we_en; w_we = we; w_addr = AW'(wa); w_d = wd;
    @(posedge clk); #1;
    idle_inputs();
    if (we_en && we) begin
      if (wa < DEPTH) model[wa] = wd;
      else exp_oor = 1'b1;
    end
    if (re) begin
      if (ra < DEPTH) exp_q = model[ra];
      else begin exp_q = '0; exp_oor = 1'b1; end
    end
    chk("r_q", r_q, exp_q);
    chk("oor_err", oor_err, exp_oor);
  endtask

  // Pulse clear and follow the engine; abort_at > 0 asserts reset after that many clear steps.
  task automatic do_clear(input int abort_at);
    int  n_busy;
    int  n_done;
    bit  fell;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    exp_oor = 1'b0;
    chk("clr_start_busy", busy, 1);
    chk("clr_start_oor", oor_err, 0);
    n_busy = busy ? 1 : 0;
    n_done = 0;
    fell   = 1'b0;
    for (int c = 1; c <= DEPTH + 20; c++) begin
      if (c == 5) begin
        w_en = 1'b1; w_we = 1'b1; w_addr = AW'(10); w_d = 16'sh5555;
        r_en = 1'b1; r_addr = AW'(3);
      end
      if (abort_at > 0 && c == abort_at + 1) reset = 1'b1;
      @(posedge clk); #1;
      idle_inputs();
      if (c == 5) begin
        exp_q = '0;
        chk("clr_read_zero", r_q, 0);
      end
      if (reset) begin
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", clear_done, 0);
        chk("abort_done_seen", n_done, 0);
        for (int i = 0; i < abort_at; i++) model[i] = '0;
        exp_q = '0;
        chk("abort_r_q", r_q, 0);
        return;
      end
      if (busy) n_busy++;
      if (clear_done) begin
        n_done++;
        chk("clr_done_busy_low", busy, 0);
      end
      if (!busy) begin
        fell = 1'b1;
        break;
      end
    end
    chk("clr_finished", fell, 1);
    chk("clr_busy_cycles", n_busy, DEPTH);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (clear_done) n_done++;
    end
    chk("clr_done_count", n_done, 1);
  endtask

  initial begin
    int ra, wa;
    logic [15:0] wd;
    idle_inputs();
    reset   = 1'b1;
    exp_q   = '0;
    exp_oor = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_r_q", r_q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", clear_done, 0);
    chk("rst_oor", oor_err, 0);

    // Full clear: establishes known contents; write at addr 10 during clear is dropped.
    do_clear(0);
    step(1, 10, 0, 0, 0, 0);
    step(1, 3, 0, 0, 0, 0);

    // Extreme values at both ends of the array.
    step(0, 0, 1, 1, 0, 16'h7FFF);
    step(0, 0, 1, 1, DEPTH - 1, 16'h8001);
    step(1, 0, 0, 0, 0, 0);
    chk("corner_lo", r_q, 32'(signed'(16'sh7FFF)));
    step(1, DEPTH - 1, 0, 0, 0, 0);
    chk("corner_hi", r_q, 32'(signed'(16'sh8001)));
    step(0, 0, 0, 0, 0, 0);

    // In-place pattern over a pre-loaded ramp.
    for (int k = 0; k <= 100; k++) step(0, 0, 1, 1, 200 + k, 16'(k * 3 + 7));
    for (int k = 0; k <= 100; k++) step(0, 0, 1, 1, k, 16'(k * 3 + 7));
    for (int k = 1; k <= 100; k++) begin
      step(1, k, 1, 1, k - 1, 16'(16'hA000 + k));
      chk("inplace_ramp", r_q, 32'(signed'(16'(k * 3 + 7))));
    end

    // Collision is write-first.
    step(1, 50, 1, 1, 50, 16'h1234);
    chk("collision", r_q, 32'h1234);

    // w_en without w_we is a no-op even out of range.
    step(0, 0, 1, 0, 8000, 16'h2222);

    // Out-of-range write then read.
    step(0, 0, 1, 1, DEPTH, 16'h1111);
    chk("oor_write_set", oor_err, 1);
    step(1, 8191, 0, 0, 0, 0);
    chk("oor_read_zero", r_q, 0);
    step(1, DEPTH - 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("oor_sticky", oor_err, 1);

    // Second clear drops oor_err and zeros everything.
    do_clear(0);
    for (int i = 0; i < 8; i++) step(1, $urandom_range(0, DEPTH - 1), 0, 0, 0, 0);
    step(1, lin3(7, 27, 27, 28), 0, 0, 0, 0);

    // Randomised traffic, mostly in a small window to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      ra = ($urandom_range(0, 15) == 0) ? $urandom_range(DEPTH, 8191) : $urandom_range(0, 63);
      wa = ($urandom_range(0, 15) == 0) ? $urandom_range(DEPTH, 8191) : $urandom_range(0, 63);
      wd = 16'($urandom);
      step(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), wa, wd);
    end

    // Aborted clear: reset after 100 cleared words.
    step(0, 0, 1, 1, 99, 16'h0BAD);
    step(0, 0, 1, 1, 200, 16'h0C0D);
    step(0, 0, 1, 1, 0, 16'h0F0F);
    do_clear(100);
    exp_oor = 1'b0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 99, 0, 0, 0, 0);
    chk("abort_word99", r_q, 0);
    step(1, 200, 0, 0, 0, 0);
    chk("abort_word200", r_q, 32'h0C0D);
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_no_done", clear_done, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
